// File: rtl/value_ptr_freelist.sv
// rtl/value_ptr_freelist.sv - FIFO free-list of value-store pointers, self-initialising after reset
module value_ptr_freelist #(
  parameter int PTR_WIDTH = 16,
  parameter int NUM_PTRS  = 1024,
  parameter int BASE_PTR  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_free_pointer_valid,
  input  logic [PTR_WIDTH-1:0]        s_free_pointer_data,
  output logic                        s_free_pointer_ready,
  output logic                        m_alloc_pointer_valid,
  output logic [PTR_WIDTH-1:0]        m_alloc_pointer_data,
  input  logic                        m_alloc_pointer_ready,
  output logic                        init_done,
  output logic [$clog2(NUM_PTRS):0]   free_count,
  output logic                        err_overflow
);

  localparam int AW = $clog2(NUM_PTRS);
  localparam int CW = AW + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [PTR_WIDTH-1:0]  mem [NUM_PTRS];
  logic [AW-1:0]         wr_idx, rd_idx;
  logic [CW-1:0]         ram_count, free_count_q;
  logic                  out_valid, err_q, init_done_q;
  logic [PTR_WIDTH-1:0]  out_data;

  logic running, hs, full, push, drop, load, init_last;

  always_comb begin
    state_d   = state_q;
    running   = (state_q == ST_RUN);
    hs        = out_valid && m_alloc_pointer_ready;
    full      = (free_count_q == CW'(NUM_PTRS));
    push      = running && s_free_pointer_valid && !(full && !hs);
    drop      = running && s_free_pointer_valid && full && !hs;
    // ram_count excludes this cycle's write, so a fresh free never bypasses the RAM
    load      = running && (!out_valid || hs) && (ram_count != '0);
    init_last = (state_q == ST_INIT) && (wr_idx == AW'(NUM_PTRS - 1));
    if (init_last) state_d = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT)
        mem[wr_idx] <= PTR_WIDTH'(BASE_PTR) + PTR_WIDTH'(wr_idx);
      else if (push)
        mem[wr_idx] <= s_free_pointer_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      wr_idx       <= '0;
      rd_idx       <= '0;
      ram_count    <= '0;
      free_count_q <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      err_q        <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        wr_idx       <= wr_idx + 1'b1;
        ram_count    <= ram_count + 1'b1;
        free_count_q <= free_count_q + 1'b1;
        if (init_last) init_done_q <= 1'b1;
      end else begin
        if (push) wr_idx <= wr_idx + 1'b1;
        if (load) begin
          out_data <= mem[rd_idx];
          rd_idx   <= rd_idx + 1'b1;
        end
        if (load)    out_valid <= 1'b1;
        else if (hs) out_valid <= 1'b0;
        ram_count    <= ram_count + CW'(push) - CW'(load);
        free_count_q <= free_count_q + CW'(push) - CW'(hs);
        if (drop) err_q <= 1'b1;
      end
    end
  end

  assign s_free_pointer_ready  = running;
  assign m_alloc_pointer_valid = out_valid;
  assign m_alloc_pointer_data  = out_data;
  assign init_done             = init_done_q;
  assign free_count            = free_count_q;
  assign err_overflow          = err_q;

endmodule

// File: tb/tb_value_ptr_freelist.sv
// tb/tb_value_ptr_freelist.sv - self-checking bench for value_ptr_freelist
module tb_value_ptr_freelist;

  localparam int PW = 16;
  localparam int NP = 8;
  localparam int BP = 16'h0100;

  logic          clk = 1'b0;
  logic          rst;
  logic          fv;
  logic [PW-1:0] fd;
  logic          fr;
  logic          av;
  logic [PW-1:0] ad;
  logic          ar;
  logic          init_done;
  logic [3:0]    fc;
  logic          err;

  value_ptr_freelist #(.PTR_WIDTH(PW), .NUM_PTRS(NP), .BASE_PTR(BP)) dut (
    .clk(clk), .rst(rst),
    .s_free_pointer_valid(fv), .s_free_pointer_data(fd), .s_free_pointer_ready(fr),
    .m_alloc_pointer_valid(av), .m_alloc_pointer_data(ad), .m_alloc_pointer_ready(ar),
    .init_done(init_done), .free_count(fc), .err_overflow(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int init_done_cyc = 1 << 30;
  logic [PW-1:0] mq[$];
  int            aq[$];
  bit            err_m = 1'b0;

  // Reference: pool is a queue; each pointer becomes visible at a known cycle
  function automatic bit m_running();
    return cyc >= init_done_cyc;
  endfunction

  function automatic bit m_valid();
    return mq.size() > 0 && aq[0] <= cyc;
  endfunction

  function automatic int m_count();
    int n;
    if (m_running()) return mq.size();
    n = cyc - (init_done_cyc - NP);
    return (n < 0) ? 0 : n;
  endfunction

  task automatic tick();
    bit hs, full;
    if (rst) begin
      mq.delete(); aq.delete(); err_m = 1'b0;
    end else if (m_running()) begin
      hs   = m_valid() && ar;
      full = (mq.size() == NP);
      if (hs) begin void'(mq.pop_front()); void'(aq.pop_front()); end
      if (fv) begin
        if (full && !hs) err_m = 1'b1;
        else begin mq.push_back(fd); aq.push_back(cyc + 2); end
      end
    end
    @(posedge clk);
    cyc++;
    if (rst) init_done_cyc = cyc + NP;
    if (cyc == init_done_cyc)
      for (int i = 0; i < NP; i++) begin
        mq.push_back(PW'(BP + i)); aq.push_back(cyc + 1);
      end
    @(negedge clk);
  endtask

  task automatic do_init();
    rst = 1'b1; fv = 1'b0; ar = 1'b0;
    tick();
    rst = 1'b0;
    repeat (NP + 1) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; fv = 1'b0; fd = '0; ar = 1'b0;
    tick(); tick();
    checks++; if (av !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", av); end
    checks++; if (ad !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", ad); end
    checks++; if (fr !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", fr); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b exp 0", init_done); end
    checks++; if (fc !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    rst = 1'b0;
    for (int i = 0; i < NP; i++) begin
      tick();
      checks++; if (init_done !== (i == NP - 1)) begin errors++; $display("FAIL init_done_timing i=%0d got %b exp %b", i, init_done, i == NP - 1); end
      checks++; if (fc !== 4'(i + 1)) begin errors++; $display("FAIL init_count i=%0d got %0d exp %0d", i, fc, i + 1); end
      checks++; if (fr !== 1'b0 && i < NP - 1) begin errors++; $display("FAIL init_ready i=%0d got %b exp 0", i, fr); end
    end
    checks++; if (av !== 1'b0) begin errors++; $display("FAIL init_valid_early got %b exp 0", av); end
    tick();
    checks++; if (av !== 1'b1 || ad !== 16'h0100) begin errors++; $display("FAIL first_alloc got %b/%h exp 1/0100", av, ad); end
  endtask

  task automatic test_drain();
    ar = 1'b1;
    for (int i = 0; i < NP; i++) begin
      checks++; if (av !== 1'b1 || ad !== PW'(BP + i)) begin errors++; $display("FAIL drain i=%0d got %b/%h exp 1/%h", i, av, ad, PW'(BP + i)); end
      tick();
    end
    checks++; if (av !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got %b exp 0", av); end
    checks++; if (fc !== 4'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", fc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL drain_err got %b exp 0", err); end
    ar = 1'b0;
  endtask

  task automatic test_latency();
    checks++; if (fr !== 1'b1) begin errors++; $display("FAIL run_ready got %b exp 1", fr); end
    fv = 1'b1; fd = 16'h0105;
    tick();
    checks++; if (av !== 1'b0 || fc !== 4'd1) begin errors++; $display("FAIL lat_t1 got %b/%0d exp 0/1", av, fc); end
    fd = 16'h0102;
    tick();
    fv = 1'b0;
    checks++; if (av !== 1'b1 || ad !== 16'h0105 || fc !== 4'd2) begin errors++; $display("FAIL lat_t2 got %b/%h/%0d exp 1/0105/2", av, ad, fc); end
    ar = 1'b1;
    tick();
    checks++; if (av !== 1'b1 || ad !== 16'h0102 || fc !== 4'd1) begin errors++; $display("FAIL lat_t3 got %b/%h/%0d exp 1/0102/1", av, ad, fc); end
    tick();
    checks++; if (av !== 1'b0 || fc !== 4'd0) begin errors++; $display("FAIL lat_t4 got %b/%0d exp 0/0", av, fc); end
    ar = 1'b0;
  endtask

  task automatic test_order();
    logic [PW-1:0] got[$];
    logic [PW-1:0] expv[6];
    int n;
    expv[0] = 16'h0103; expv[1] = 16'h0104; expv[2] = 16'h0105;
    expv[3] = 16'h0106; expv[4] = 16'h0107; expv[5] = 16'h0101;
    do_init();
    ar = 1'b1;
    repeat (3) tick();
    ar = 1'b0; fv = 1'b1; fd = 16'h0101;
    tick();
    fv = 1'b0; ar = 1'b1;
    n = 0;
    while (av && n < 20) begin got.push_back(ad); tick(); n++; end
    ar = 1'b0;
    checks++; if (got.size() != 6) begin errors++; $display("FAIL order_len got %0d exp 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++; if (got[i] !== expv[i]) begin errors++; $display("FAIL order i=%0d got %h exp %h", i, got[i], expv[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [PW-1:0] got[$];
    int n;
    bit seen_ff;
    do_init();
    fv = 1'b1; fd = 16'h01FF;
    tick();
    checks++; if (err !== 1'b1 || fc !== 4'd8) begin errors++; $display("FAIL drop got %b/%0d exp 1/8", err, fc); end
    fd = 16'h01FE; ar = 1'b1;
    tick();
    fv = 1'b0;
    checks++; if (err !== 1'b1 || fc !== 4'd8) begin errors++; $display("FAIL full_swap got %b/%0d exp 1/8", err, fc); end
    n = 0;
    while (av && n < 20) begin got.push_back(ad); tick(); n++; end
    ar = 1'b0;
    seen_ff = 1'b0;
    foreach (got[i]) if (got[i] === 16'h01FF) seen_ff = 1'b1;
    checks++; if (got.size() != 8) begin errors++; $display("FAIL ovf_len got %0d exp 8", got.size()); end
    checks++; if (got.size() == 0 || got[got.size()-1] !== 16'h01FE) begin errors++; $display("FAIL ovf_last got %h exp 01fe", (got.size() > 0) ? got[got.size()-1] : 16'hxxxx); end
    checks++; if (seen_ff) begin errors++; $display("FAIL ovf_dropped_present got 1 exp 0"); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", err); end
  endtask

  task automatic test_reset_mid();
    do_init();
    fv = 1'b1; fd = 16'h01FF;
    tick();
    fv = 1'b0; ar = 1'b1;
    repeat (3) tick();
    ar = 1'b0;
    rst = 1'b1; fv = 1'b1; fd = 16'h01AA;
    tick();
    rst = 1'b0; fv = 1'b0;
    checks++; if (av !== 1'b0 || init_done !== 1'b0 || fc !== 4'd0 || err !== 1'b0)
      begin errors++; $display("FAIL midrst got v%b i%b c%0d e%b exp v0 i0 c0 e0", av, init_done, fc, err); end
    repeat (NP) tick();
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL midrst_init got %b exp 1", init_done); end
    tick();
    checks++; if (av !== 1'b1 || ad !== 16'h0100) begin errors++; $display("FAIL midrst_restart got %b/%h exp 1/0100", av, ad); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      checks++; if (av !== m_valid()) begin errors++; $display("FAIL rnd_valid cyc=%0d got %b exp %b", cyc, av, m_valid()); end
      if (m_valid()) begin
        checks++; if (ad !== mq[0]) begin errors++; $display("FAIL rnd_data cyc=%0d got %h exp %h", cyc, ad, mq[0]); end
      end
      checks++; if (fc !== 4'(m_count())) begin errors++; $display("FAIL rnd_count cyc=%0d got %0d exp %0d", cyc, fc, m_count()); end
      checks++; if (err !== err_m) begin errors++; $display("FAIL rnd_err cyc=%0d got %b exp %b", cyc, err, err_m); end
      checks++; if (init_done !== m_running() || fr !== m_running())
        begin errors++; $display("FAIL rnd_state cyc=%0d got %b/%b exp %b", cyc, init_done, fr, m_running()); end
      rst = ($urandom_range(0, 299) == 0);
      fv = ($urandom_range(0, 3) != 0);
      fd = PW'($urandom);
      ar = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; fv = 1'b0; ar = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fv = 1'b0; fd = '0; ar = 1'b0;
    @(negedge clk);
    test_reset();
    test_drain();
    test_latency();
    test_order();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
